// File: rtl/sel_arb_pkg.sv
// Shared types and encodings for the round-robin selector arbiter.
// Select codes are active-low toward the selector; grant codes are one-hot {C,B,A}.
package sel_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [1:0] SW_IDLE = 2'b11;
    localparam logic [1:0] SW_A    = 2'b10;
    localparam logic [1:0] SW_B    = 2'b01;
    localparam logic [1:0] SW_C    = 2'b00;

    localparam logic [2:0] GNT_A = 3'b001;
    localparam logic [2:0] GNT_B = 3'b010;
    localparam logic [2:0] GNT_C = 3'b100;

    function automatic logic [1:0] gnt2sw(input logic [2:0] g);
        case (g)
            GNT_A:   return SW_A;
            GNT_B:   return SW_B;
            GNT_C:   return SW_C;
            default: return SW_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way rotating-priority picker: search starts at the requester after 'last'.
module rr_pick3
    import sel_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] last,
    output logic [2:0] win,
    output logic       valid
);

    always_comb begin
        win = '0;
        case (last)
            GNT_A: begin
                if      (req[1]) win = GNT_B;
                else if (req[2]) win = GNT_C;
                else if (req[0]) win = GNT_A;
            end
            GNT_B: begin
                if      (req[2]) win = GNT_C;
                else if (req[0]) win = GNT_A;
                else if (req[1]) win = GNT_B;
            end
            // GNT_C, and any corrupted pointer, restarts at A
            default: begin
                if      (req[0]) win = GNT_A;
                else if (req[1]) win = GNT_B;
                else if (req[2]) win = GNT_C;
            end
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin owner of the 3-way selector: fixed hold window per grant,
// one forced idle (GAP) cycle between grants, registered data/enable copy.
module sel_rr_arbiter
    import sel_arb_pkg::*;
#(
    parameter  int HOLD_CYCLES = 27000000,
    localparam int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iReqA,
    input  logic       iReqB,
    input  logic       iReqC,
    input  logic [2:0] iA,
    input  logic [2:0] iB,
    input  logic [2:0] iC,
    output logic [1:0] oSwN,
    output logic [2:0] oGnt,
    output logic [2:0] oOut,
    output logic       oEn,
    output logic       oDone,
    output logic       oBusy
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > (1 << 26)) begin : g_bad_hold
        $error("sel_rr_arbiter: HOLD_CYCLES must be in 1..2^26");
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      last;
    logic [2:0]      req;
    logic [2:0]      win;
    logic            valid;
    logic [2:0]      arb_data;
    logic [2:0]      own_data;

    assign req = {iReqC, iReqB, iReqA};

    rr_pick3 u_pick (
        .req   (req),
        .last  (last),
        .win   (win),
        .valid (valid)
    );

    // One-hot AND-OR muxes: new winner's data and current owner's data
    assign arb_data = ({3{win[0]}}  & iA) | ({3{win[1]}}  & iB) | ({3{win[2]}}  & iC);
    assign own_data = ({3{oGnt[0]}} & iA) | ({3{oGnt[1]}} & iB) | ({3{oGnt[2]}} & iC);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= GNT_C;
            oGnt  <= '0;
            oSwN  <= SW_IDLE;
            oOut  <= '0;
            oEn   <= 1'b0;
            oDone <= 1'b0;
            oBusy <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                GRANT: begin
                    cnt  <= cnt + CW'(1);
                    oOut <= own_data;
                    // owner dropped its request, or the window is used up
                    if (!(|(req & oGnt)) || cnt == CW'(HOLD_CYCLES - 1)) begin
                        state <= GAP;
                        oGnt  <= '0;
                        oSwN  <= SW_IDLE;
                        oOut  <= '0;
                        oEn   <= 1'b0;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end
                end
                default: begin
                    if (valid) begin
                        state <= GRANT;
                        last  <= win;
                        cnt   <= '0;
                        oGnt  <= win;
                        oSwN  <= gnt2sw(win);
                        oOut  <= arb_data;
                        oEn   <= 1'b1;
                        oBusy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Bench for sel_rr_arbiter: index-based round-robin model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sel_rr_arbiter;

    localparam int HOLD = 4;

    logic       iClk = 1'b0;
    logic       iRst, iReqA, iReqB, iReqC;
    logic [2:0] iA, iB, iC;
    logic [1:0] oSwN;
    logic [2:0] oGnt, oOut;
    logic       oEn, oDone, oBusy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    sel_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iReqA (iReqA),
        .iReqB (iReqB),
        .iReqC (iReqC),
        .iA    (iA),
        .iB    (iB),
        .iC    (iC),
        .oSwN  (oSwN),
        .oGnt  (oGnt),
        .oOut  (oOut),
        .oEn   (oEn),
        .oDone (oDone),
        .oBusy (oBusy)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=idle 1=grant 2=gap; owner/last are indices 0=A,1=B,2=C
    int m_state = 0, m_own = 0, m_cnt = 0, m_last = 2;
    logic [2:0] e_gnt = '0, e_out = '0;
    logic [1:0] e_swn = 2'b11;
    logic       e_en = 0, e_done = 0, e_busy = 0;

    always @(posedge iClk) begin : model_b
        logic [2:0] r;
        logic [2:0] d [3];
        int f;
        r = {iReqC, iReqB, iReqA};
        d[0] = iA; d[1] = iB; d[2] = iC;
        if (iRst) begin
            m_state = 0; m_cnt = 0; m_last = 2;
        end else if (m_state == 1) begin
            m_cnt++;
            if (!r[m_own] || m_cnt >= HOLD) m_state = 2;
        end else begin
            f = -1;
            for (int k = 1; k <= 3; k++)
                if (f < 0 && r[(m_last + k) % 3]) f = (m_last + k) % 3;
            if (f >= 0) begin
                m_state = 1; m_own = f; m_last = f; m_cnt = 0;
            end else begin
                m_state = 0;
            end
        end
        e_gnt  = (m_state == 1) ? 3'(1 << m_own) : 3'b000;
        e_swn  = (m_state == 1) ? 2'(2 - m_own) : 2'b11;
        e_out  = (m_state == 1) ? d[m_own] : 3'b000;
        e_en   = (m_state == 1);
        e_busy = (m_state == 1);
        e_done = (m_state == 2);
    end

    always @(negedge iClk) begin
        if (chk_en) begin
            chk("model_gnt",  8'(oGnt),  8'(e_gnt));
            chk("model_swn",  8'(oSwN),  8'(e_swn));
            chk("model_out",  8'(oOut),  8'(e_out));
            chk("model_en",   8'(oEn),   8'(e_en));
            chk("model_done", 8'(oDone), 8'(e_done));
            chk("model_busy", 8'(oBusy), 8'(e_busy));
        end
    end

    // Returns just after a rising edge has been applied and settled
    task automatic tick();
        @(negedge iClk);
        #1;
    endtask

    task automatic rst_seq(input logic [2:0] reqs);
        iRst = 1'b1;
        {iReqC, iReqB, iReqA} = reqs;
        tick();
        tick();
        iRst = 1'b0;
    endtask

    logic [1:0] sw_h [16];
    logic [1:0] sw_exp [7];
    int         sw_idx [7];
    logic [1:0] t2_sw [6];
    logic       t2_dn [6];

    initial begin
        iRst = 1'b1; iReqA = 0; iReqB = 0; iReqC = 0;
        iA = 3'b000; iB = 3'b000; iC = 3'b000;
        tick();
        chk_en = 1'b1;

        // Idle after reset
        rst_seq(3'b000);
        for (int s = 0; s < 10; s++) begin
            tick();
            chk("idle_swn",  8'(oSwN),  8'h3);
            chk("idle_done", 8'(oDone), 8'h0);
            chk("idle_en",   8'(oEn),   8'h0);
            chk("idle_out",  8'(oOut),  8'h0);
        end

        // Single requester A, period HOLD+1
        t2_sw = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
        t2_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        iA = 3'b101; iReqA = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            chk("single_swn",  8'(oSwN),  8'(t2_sw[s]));
            chk("single_done", 8'(oDone), 8'(t2_dn[s]));
            if (s == 0) chk("single_out", 8'(oOut), 8'h5);
        end
        iReqA = 1'b0;

        // All three from reset: A,B,C,A with gaps
        iA = 3'b001; iB = 3'b010; iC = 3'b011;
        sw_exp = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10};
        sw_idx = '{0, 4, 5, 9, 10, 14, 15};
        rst_seq(3'b111);
        for (int s = 0; s < 16; s++) begin
            tick();
            sw_h[s] = oSwN;
            if (s == 5)  chk("rr_gnt_b", 8'(oGnt), 8'h2);
            if (s == 10) chk("rr_out_c", 8'(oOut), 8'h3);
        end
        for (int i = 0; i < 7; i++) chk("rr_swn_seq", 8'(sw_h[sw_idx[i]]), 8'(sw_exp[i]));

        // B early release in its 2nd cycle; next priority starts at C
        rst_seq(3'b010);
        tick(); chk("early_gnt0", 8'(oGnt), 8'h2);
        tick(); chk("early_gnt1", 8'(oGnt), 8'h2);
        iReqB = 1'b0; iReqA = 1'b1; iReqC = 1'b1;
        tick(); chk("early_done", 8'(oDone), 8'h1);
                chk("early_swn",  8'(oSwN),  8'h3);
        tick(); chk("early_next", 8'(oGnt),  8'h4);

        // Data tracking mid-grant and no preemption
        rst_seq(3'b000);
        iA = 3'b010; iReqA = 1'b1;
        tick(); chk("track_out0", 8'(oOut), 8'h2);
                chk("track_gnt0", 8'(oGnt), 8'h1);
        iA = 3'b111; iReqC = 1'b1;
        tick(); chk("track_out1", 8'(oOut), 8'h7);
        tick(); chk("nopre_gnt2", 8'(oGnt), 8'h1);
        tick(); chk("nopre_gnt3", 8'(oGnt), 8'h1);
        tick(); chk("nopre_done", 8'(oDone), 8'h1);
        tick(); chk("nopre_next", 8'(oGnt), 8'h4);

        // Reset during cycle 3 of a C grant
        rst_seq(3'b111);
        for (int s = 0; s < 13; s++) tick();
        chk("midrst_pre", 8'(oGnt), 8'h4);
        iRst = 1'b1;
        tick();
        chk("midrst_gnt",  8'(oGnt),  8'h0);
        chk("midrst_swn",  8'(oSwN),  8'h3);
        chk("midrst_done", 8'(oDone), 8'h0);
        chk("midrst_en",   8'(oEn),   8'h0);
        chk("midrst_out",  8'(oOut),  8'h0);
        chk("midrst_busy", 8'(oBusy), 8'h0);
        iRst = 1'b0;
        tick();
        chk("midrst_first", 8'(oGnt), 8'h1);

        // Randomized traffic, model checks every cycle
        for (int s = 0; s < 3000; s++) begin
            if ($urandom_range(5) == 0) iReqA = ~iReqA;
            if ($urandom_range(5) == 0) iReqB = ~iReqB;
            if ($urandom_range(5) == 0) iReqC = ~iReqC;
            iA = 3'($urandom);
            iB = 3'($urandom);
            iC = 3'($urandom);
            iRst = ($urandom_range(149) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
